// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, ALU-op encodings and the control bundle that rides the pipeline.
// The multiply opcode is only decoded when CTRL_MUL_EN is defined.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b001100;
    localparam logic [5:0] OP_MUL   = 6'b011100;

    localparam int ALU_OP_BITS = 2;
    localparam logic [ALU_OP_BITS-1:0] ALU_NONE   = 2'b00;
    localparam logic [ALU_OP_BITS-1:0] ALU_BRANCH = 2'b01;
    localparam logic [ALU_OP_BITS-1:0] ALU_RTYPE  = 2'b10;
    localparam logic [ALU_OP_BITS-1:0] ALU_MEM    = 2'b11;

    typedef struct packed {
        logic                   reg_dst;
        logic                   reg_write;
        logic                   mem_to_reg;
        logic [ALU_OP_BITS-1:0] alu_op;
        logic                   alu_src;
        logic                   mem_read;
        logic                   mem_write;
        logic                   branch;
        logic                   jump;
        logic                   mul;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// ID-stage opcode decoder: purely combinational opcode -> control bundle.
// Opcode 011100 decodes as MUL only when CTRL_MUL_EN is defined.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_bundle_t        ctrl
);

    always_comb begin
        ctrl = CTRL_BUBBLE;
        case (opcode)
            OPCODE_W'(OP_RTYPE): begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_op     = ALU_RTYPE;
            end
            OPCODE_W'(OP_LW): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_op    = ALU_MEM;
            end
            OPCODE_W'(OP_SW): begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALU_MEM;
            end
            OPCODE_W'(OP_BEQ): begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_BRANCH;
            end
            OPCODE_W'(OP_J): begin
                ctrl.jump = 1'b1;
            end
`ifdef CTRL_MUL_EN
            OPCODE_W'(OP_MUL): begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_op     = ALU_RTYPE;
                ctrl.mul        = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control for the 5-stage MIPS core: decode, ID/EX/MEM/WB control registers,
// load-use stall, branch/jump flush. CTRL_MUL_EN adds the multi-cycle multiply sequencer.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int REG_W    = 5,
    parameter int ALU_OP_W = 2,
    parameter int MUL_LAT  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                branch_taken,
    output logic                stall,
    output logic                flush_ifid,
    output logic                pc_src,
    output logic                jump,
    output logic                ex_alu_src,
    output logic                ex_reg_dst,
    output logic                ex_branch,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_mul,
    output logic                mem_read,
    output logic                mem_write,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic [REG_W-1:0]    wb_dst
);

    ctrl_bundle_t     id_ctrl, idex_ctrl, idex_d, exmem_ctrl, exmem_d, memwb_ctrl;
    logic [REG_W-1:0] id_dst, idex_dst, idex_dst_d, exmem_dst, exmem_dst_d, memwb_dst;
    logic             br_take, load_use, mul_busy;

    ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode (id_opcode),
        .ctrl   (id_ctrl)
    );

    // Instructions that never write back carry dst 0 so hazard checks ignore them.
    assign id_dst = id_ctrl.reg_write ? (id_ctrl.reg_dst ? id_rd : id_rt) : '0;

    assign br_take  = idex_ctrl.branch & branch_taken;
    assign load_use = idex_ctrl.mem_read && (idex_dst != '0) &&
                      ((idex_dst == id_rs) || (idex_dst == id_rt));

    assign pc_src     = br_take;
    assign stall      = !br_take && (mul_busy || load_use);
    assign jump       = !br_take && !mul_busy && !load_use && id_ctrl.jump;
    assign flush_ifid = br_take | jump;

    always_comb begin
        idex_d      = id_ctrl;
        idex_dst_d  = id_dst;
        exmem_d     = idex_ctrl;
        exmem_dst_d = idex_dst;
        if (br_take) begin
            idex_d     = CTRL_BUBBLE;
            idex_dst_d = '0;
        end else if (mul_busy) begin
            idex_d     = idex_ctrl;
            idex_dst_d = idex_dst;
        end else if (load_use || id_ctrl.jump) begin
            idex_d     = CTRL_BUBBLE;
            idex_dst_d = '0;
        end
        if (mul_busy) begin
            exmem_d     = CTRL_BUBBLE;
            exmem_dst_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_ctrl  <= CTRL_BUBBLE;
            exmem_ctrl <= CTRL_BUBBLE;
            memwb_ctrl <= CTRL_BUBBLE;
            idex_dst   <= '0;
            exmem_dst  <= '0;
            memwb_dst  <= '0;
        end else begin
            idex_ctrl  <= idex_d;
            exmem_ctrl <= exmem_d;
            memwb_ctrl <= exmem_ctrl;
            idex_dst   <= idex_dst_d;
            exmem_dst  <= exmem_dst_d;
            memwb_dst  <= exmem_dst;
        end
    end

`ifdef CTRL_MUL_EN
    localparam int CNT_W = $clog2(MUL_LAT);

    typedef enum logic {MUL_IDLE, MUL_BUSY} mul_state_t;

    mul_state_t       mul_state;
    logic [CNT_W-1:0] mul_cnt;

    // BUSY covers the first MUL_LAT-1 EX cycles; the last EX cycle runs unstalled
    // so the MUL drains to MEM on the edge after the count reaches 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_state <= MUL_IDLE;
            mul_cnt   <= '0;
        end else begin
            case (mul_state)
                MUL_IDLE: begin
                    if (idex_d.mul) begin
                        mul_state <= MUL_BUSY;
                        mul_cnt   <= CNT_W'(MUL_LAT - 1);
                    end
                end
                MUL_BUSY: begin
                    mul_cnt <= mul_cnt - 1'b1;
                    if (mul_cnt == CNT_W'(1)) mul_state <= MUL_IDLE;
                end
                default: mul_state <= MUL_IDLE;
            endcase
        end
    end

    assign mul_busy = (mul_state == MUL_BUSY);
    assign ex_mul   = idex_ctrl.mul;
`else
    assign mul_busy = 1'b0;
    assign ex_mul   = 1'b0;

    logic unused_mul;
    assign unused_mul = ^{idex_ctrl.mul, 32'(MUL_LAT)};
`endif

    assign ex_alu_src    = idex_ctrl.alu_src;
    assign ex_reg_dst    = idex_ctrl.reg_dst;
    assign ex_branch     = idex_ctrl.branch;
    assign ex_alu_op     = ALU_OP_W'(idex_ctrl.alu_op);
    assign mem_read      = exmem_ctrl.mem_read;
    assign mem_write     = exmem_ctrl.mem_write;
    assign wb_reg_write  = memwb_ctrl.reg_write;
    assign wb_mem_to_reg = memwb_ctrl.mem_to_reg;
    assign wb_dst        = memwb_dst;

    // Later stages only consume a subset of the bundle.
    logic unused_bits;
    assign unused_bits = ^{idex_ctrl.jump, idex_ctrl.reg_write, idex_ctrl.mem_to_reg,
                           idex_ctrl.mem_read, idex_ctrl.mem_write, exmem_ctrl, memwb_ctrl};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed, table-driven bench for pipe_ctrl_unit; MUL sequences follow CTRL_MUL_EN.
module tb_pipe_ctrl_unit;

    localparam logic [5:0] R   = 6'b000001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] J   = 6'b001100;
    localparam logic [5:0] MUL = 6'b011100;
    localparam logic [5:0] NOP = 6'b000000;
    localparam logic [5:0] UNK = 6'b111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] id_opcode = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       branch_taken = 1'b0;
    logic       stall, flush_ifid, pc_src, jump;
    logic       ex_alu_src, ex_reg_dst, ex_branch, ex_mul;
    logic [1:0] ex_alu_op;
    logic       mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
    logic [4:0] wb_dst;

    pipe_ctrl_unit dut (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .branch_taken(branch_taken), .stall(stall), .flush_ifid(flush_ifid),
        .pc_src(pc_src), .jump(jump), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
        .ex_branch(ex_branch), .ex_alu_op(ex_alu_op), .ex_mul(ex_mul), .mem_read(mem_read),
        .mem_write(mem_write), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_dst(wb_dst)
    );

    always #5 clk = ~clk;

    // exp = {stall,flush,pc_src,jump, alu_src,reg_dst,branch, alu_op, mul, mrd,mwr, rw,m2r, dst}
    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic        bt;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   applied = 0;
    int   miscompares = 0;

    function automatic logic [18:0] e(input logic [3:0] ctl, input logic [2:0] exf,
                                      input logic [1:0] aop, input logic mul,
                                      input logic [1:0] mem, input logic [1:0] wb,
                                      input logic [4:0] dst);
        return {ctl, exf, aop, mul, mem, wb, dst};
    endfunction

    function automatic vec_t mk(input logic r, input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic bt,
                                input logic [18:0] exp);
        vec_t v;
        v.rst = r; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.bt = bt; v.exp = exp;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string name);
        logic [18:0] got;
        @(posedge clk);
        #1;
        rst = v.rst; id_opcode = v.op; id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
        branch_taken = v.bt;
        @(negedge clk);
        got = {stall, flush_ifid, pc_src, jump, ex_alu_src, ex_reg_dst, ex_branch,
               ex_alu_op, ex_mul, mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_dst};
        applied++;
        if (got !== v.exp) begin
            miscompares++;
            $display("FAIL %s: got %b required %b", name, got, v.exp);
        end
    endtask

    localparam logic [18:0] Z = 19'd0;

    initial begin
        // reset, then LW flows EX -> MEM -> WB
        tbl.push_back(mk(1, LW,  0, 1, 0, 0, Z));
        tbl.push_back(mk(1, LW,  0, 1, 0, 0, Z));
        tbl.push_back(mk(0, LW,  0, 1, 0, 0, Z));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, e(4'b0000, 3'b100, 2'b11, 0, 2'b00, 2'b00, 0)));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, e(4'b0000, 3'b000, 2'b00, 0, 2'b10, 2'b00, 0)));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, e(4'b0000, 3'b000, 2'b00, 0, 2'b00, 2'b10, 1)));
        // load-use: LW rt=5 then R rs=5
        tbl.push_back(mk(0, LW,  0, 5, 0, 0, Z));
        tbl.push_back(mk(0, R,   5, 2, 9, 0, e(4'b1000, 3'b100, 2'b11, 0, 2'b00, 2'b00, 0)));
        tbl.push_back(mk(0, R,   5, 2, 9, 0, e(4'b0000, 3'b000, 2'b00, 0, 2'b10, 2'b00, 0)));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, e(4'b0000, 3'b010, 2'b10, 0, 2'b00, 2'b10, 5)));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, Z));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, e(4'b0000, 3'b000, 2'b00, 0, 2'b00, 2'b11, 9)));
        // LW rt=0 then R rs=0: no stall
        tbl.push_back(mk(0, LW,  3, 0, 0, 0, Z));
        tbl.push_back(mk(0, R,   0, 0, 4, 0, e(4'b0000, 3'b100, 2'b11, 0, 2'b00, 2'b00, 0)));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, e(4'b0000, 3'b010, 2'b10, 0, 2'b10, 2'b00, 0)));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, e(4'b0000, 3'b000, 2'b00, 0, 2'b00, 2'b10, 0)));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, e(4'b0000, 3'b000, 2'b00, 0, 2'b00, 2'b11, 4)));
        // taken BEQ in EX cancels a J in ID; bt ignored when EX is not a branch
        tbl.push_back(mk(0, BEQ, 1, 2, 0, 0, Z));
        tbl.push_back(mk(0, J,   0, 0, 0, 1, e(4'b0110, 3'b001, 2'b01, 0, 2'b00, 2'b00, 0)));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 1, Z));
        // not-taken BEQ
        tbl.push_back(mk(0, BEQ, 1, 2, 0, 0, Z));
        tbl.push_back(mk(0, R,   1, 2, 3, 0, e(4'b0000, 3'b001, 2'b01, 0, 2'b00, 2'b00, 0)));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, e(4'b0000, 3'b010, 2'b10, 0, 2'b00, 2'b00, 0)));
        // jump in ID, then EX bubble
        tbl.push_back(mk(0, J,   0, 0, 0, 0, e(4'b0101, 3'b000, 2'b00, 0, 2'b00, 2'b00, 0)));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, e(4'b0000, 3'b000, 2'b00, 0, 2'b00, 2'b11, 3)));
        // SW, unknown opcode as NOP
        tbl.push_back(mk(0, SW,  1, 2, 0, 0, Z));
        tbl.push_back(mk(0, UNK, 0, 0, 0, 0, e(4'b0000, 3'b100, 2'b11, 0, 2'b00, 2'b00, 0)));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, e(4'b0000, 3'b000, 2'b00, 0, 2'b01, 2'b00, 0)));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, Z));
        // load-use outranks jump
        tbl.push_back(mk(0, LW,  0, 6, 0, 0, Z));
        tbl.push_back(mk(0, J,   6, 0, 0, 0, e(4'b1000, 3'b100, 2'b11, 0, 2'b00, 2'b00, 0)));
        tbl.push_back(mk(0, J,   6, 0, 0, 0, e(4'b0101, 3'b000, 2'b00, 0, 2'b10, 2'b00, 0)));
        tbl.push_back(mk(0, NOP, 0, 0, 0, 0, e(4'b0000, 3'b000, 2'b00, 0, 2'b00, 2'b10, 6)));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

`ifdef CTRL_MUL_EN
        // MUL_LAT=4: three stalled cycles, one free EX cycle, WB two cycles after EX
        run_vec(mk(0, MUL, 1, 2, 7, 0, Z), "mul_issue");
        for (int k = 0; k < 3; k++)
            run_vec(mk(0, R, 0, 0, 8, 0, e(4'b1000, 3'b010, 2'b10, 1, 2'b00, 2'b00, 0)),
                    $sformatf("mul_busy%0d", k));
        run_vec(mk(0, R,   0, 0, 8, 0, e(4'b0000, 3'b010, 2'b10, 1, 2'b00, 2'b00, 0)), "mul_last");
        run_vec(mk(0, NOP, 0, 0, 0, 0, e(4'b0000, 3'b010, 2'b10, 0, 2'b00, 2'b00, 0)), "mul_next");
        run_vec(mk(0, NOP, 0, 0, 0, 0, e(4'b0000, 3'b000, 2'b00, 0, 2'b00, 2'b11, 7)), "mul_wb");
        // reset during BUSY
        run_vec(mk(0, MUL, 0, 0, 7, 0, e(4'b0000, 3'b000, 2'b00, 0, 2'b00, 2'b11, 8)), "mul2_issue");
        run_vec(mk(1, NOP, 0, 0, 0, 0, e(4'b1000, 3'b010, 2'b10, 1, 2'b00, 2'b00, 0)), "mul2_rst");
        run_vec(mk(0, NOP, 0, 0, 0, 0, Z), "mul2_after_rst");
`else
        // MUL opcode is a NOP without the multiplier
        run_vec(mk(0, MUL, 1, 2, 7, 0, Z), "mulnop_id");
        run_vec(mk(0, NOP, 0, 0, 0, 0, Z), "mulnop_ex");
        run_vec(mk(0, NOP, 0, 0, 0, 0, Z), "mulnop_mem");
        run_vec(mk(0, NOP, 0, 0, 0, 0, Z), "mulnop_wb");
`endif
        // reset mid-operation clears an LW in EX
        run_vec(mk(0, LW,  0, 3, 0, 0, Z), "rst_lw");
        run_vec(mk(1, R,   3, 0, 1, 0, e(4'b1000, 3'b100, 2'b11, 0, 2'b00, 2'b00, 0)), "rst_hit");
        run_vec(mk(0, NOP, 0, 0, 0, 0, Z), "rst_clear");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
